// File: rtl/main_mul_share_arb.sv
// Round-robin front end sharing one external combinational multiplier among NUM_REQ requesters.
// Two-stage pipeline: S1 holds the granted operands, S2 holds the product until it is accepted.
module main_mul_share_arb #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DIN0_WIDTH = 10,
   parameter int unsigned DIN1_WIDTH = 9,
   parameter int unsigned DOUT_WIDTH = 18,
   parameter int unsigned ID_WIDTH   = 2
) (
   input  logic                             ap_clk,
   input  logic                             ap_rst,
   input  logic [NUM_REQ-1:0]               req_valid,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic [NUM_REQ*DIN0_WIDTH-1:0]    req_din0,
   input  logic [NUM_REQ*DIN1_WIDTH-1:0]    req_din1,
   output logic [NUM_REQ-1:0]               resp_valid,
   input  logic [NUM_REQ-1:0]               resp_ready,
   output logic [DOUT_WIDTH-1:0]            resp_dout,
   output logic [DIN0_WIDTH-1:0]            mul_din0,
   output logic [DIN1_WIDTH-1:0]            mul_din1,
   input  logic [DOUT_WIDTH-1:0]            mul_dout,
   output logic                             busy
);

   logic                  s1_valid_q, s1_valid_d;
   logic                  s2_valid_q, s2_valid_d;
   logic [ID_WIDTH-1:0]   s1_id_q, s1_id_d;
   logic [ID_WIDTH-1:0]   s2_id_q, s2_id_d;
   logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
   logic [DIN0_WIDTH-1:0] s1_din0_q, s1_din0_d;
   logic [DIN1_WIDTH-1:0] s1_din1_q, s1_din1_d;
   logic [DOUT_WIDTH-1:0] res_q, res_d;

   logic                  resp_fire, s2_load, accept_en, accept;
   logic                  grant_any;
   logic [NUM_REQ-1:0]    grant;
   logic [ID_WIDTH-1:0]   gnt_id;
   logic [ID_WIDTH-1:0]   scan_idx;

   // First valid requester at or after rr_ptr, wrapping around.
   always_comb begin
      grant     = '0;
      gnt_id    = '0;
      grant_any = 1'b0;
      scan_idx  = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         scan_idx = ID_WIDTH'((32'(rr_ptr_q) + k) % NUM_REQ);
         if (!grant_any && req_valid[scan_idx]) begin
            grant[scan_idx] = 1'b1;
            gnt_id          = scan_idx;
            grant_any       = 1'b1;
         end
      end
   end

   assign resp_fire = s2_valid_q & resp_ready[s2_id_q];
   assign s2_load   = s1_valid_q & (~s2_valid_q | resp_fire);
   assign accept_en = ~s1_valid_q | s2_load;
   // Gate with reset so no handshake can complete while the pipeline is being cleared.
   assign accept    = grant_any & accept_en & ~ap_rst;
   assign req_ready = accept ? grant : '0;

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_id_d    = s1_id_q;
      s1_din0_d  = s1_din0_q;
      s1_din1_d  = s1_din1_q;
      rr_ptr_d   = rr_ptr_q;
      s2_valid_d = s2_valid_q;
      s2_id_d    = s2_id_q;
      res_d      = res_q;

      if (s2_load) begin
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b1;
         s2_id_d    = s1_id_q;
         res_d      = mul_dout;
      end else if (resp_fire) begin
         s2_valid_d = 1'b0;
      end

      if (accept) begin
         s1_valid_d = 1'b1;
         s1_id_d    = gnt_id;
         s1_din0_d  = req_din0[32'(gnt_id)*DIN0_WIDTH +: DIN0_WIDTH];
         s1_din1_d  = req_din1[32'(gnt_id)*DIN1_WIDTH +: DIN1_WIDTH];
         rr_ptr_d   = (gnt_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
      end
   end

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s1_id_q    <= '0;
         s2_id_q    <= '0;
         rr_ptr_q   <= '0;
         s1_din0_q  <= '0;
         s1_din1_q  <= '0;
         res_q      <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         s1_id_q    <= s1_id_d;
         s2_id_q    <= s2_id_d;
         rr_ptr_q   <= rr_ptr_d;
         s1_din0_q  <= s1_din0_d;
         s1_din1_q  <= s1_din1_d;
         res_q      <= res_d;
      end
   end

   always_comb begin
      resp_valid = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         resp_valid[i] = s2_valid_q && (s2_id_q == ID_WIDTH'(i));
      end
   end

   assign resp_dout = res_q;
   assign mul_din0  = s1_din0_q;
   assign mul_din1  = s1_din1_q;
   assign busy      = s1_valid_q | s2_valid_q;

endmodule
